addsub_result_stage: RTL and testbench
======================================

// Module: addsub_result_stage
// PURPOSE
//  Downstream stage of the 8-bit ripple-carry adder/subtractor. Captures Sum/Cout with the op mode
//  and operand sign bits. Derives the status flags, buffers result+flags in a small FIFO and hands
//  them on over a valid/ready interface. Decouples the combinational adder from stalling consumers.
// PARAMETERS
//  WIDTH  8  datapath width; must match the adder/subtractor
//  DEPTH  2  FIFO entries; power of two, >=2
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous active-high reset
//  in_valid    in   1      Sum/Cout/Sub/A_msb/B_msb valid this cycle
//  in_ready    out  1      stage accepts a push this cycle
//  Sum         in   WIDTH  adder/subtractor sum
//  Cout        in   1      adder/subtractor carry out
//  Sub         in   1      op mode used by the adder (its Cin): 0=A+B, 1=A-B
//  A_msb       in   1      A[WIDTH-1] as presented to the adder
//  B_msb       in   1      B[WIDTH-1] before the Sub inversion
//  out_valid   out  1      head entry valid
//  out_ready   in   1      consumer accepts head
//  out_result  out  WIDTH  head result
//  out_flags   out  4      head flags {N,Z,V,CB}
//  ovf_count   out  8      saturating count of accepted pushes with V=1
//  ovf_clr     in   1      clears ovf_count
// BEHAVIOUR
//  Flags, computed combinationally at push time and stored with the entry:
//   CB = Sub ? ~Cout : Cout. This is carry for add and borrow for sub.
//   V  = (A_msb == (B_msb^Sub)) && (Sum[WIDTH-1] != A_msb).
//   N  = stored result MSB.
//   Z  = (stored result == 0).
//  push = in_valid & in_ready.
//  pop  = out_valid & out_ready.
//  in_ready = (count != DEPTH) & ~rst. It depends only on count. It never depends on out_ready.
//  When full, a same-cycle pop does not enable a push.
//  out_valid = (count != 0). out_result/out_flags are driven from the head entry, not from Sum.
//  Latency: an entry pushed at edge n is visible on out_* after edge n (one-cycle latency).
//  There is no fall-through path from input to output.
//  Ordering: entries are strictly FIFO. Head data must hold stable while out_valid & ~out_ready.
//  Pointers: wr_ptr/rd_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH.
//  count is log2(DEPTH)+1 bits wide.
//  Simultaneous push and pop (0<count<DEPTH): count is unchanged and both pointers advance.
//  Push with count==0: out_valid rises next cycle. Pop at count==1 with no push: out_valid falls next cycle.
//  ovf_count: +1 per push with V=1, saturating at 255.
//   ovf_clr has priority; clr and a V push in the same cycle give 0.
//  Reset, including mid-transfer: count=0, pointers=0, out_valid=0, in_ready=0 during rst.
//   ovf_count=0. out_result=0 and out_flags=0 (storage cleared). In-flight entries are discarded.
// CONFIGURATION
//  ADDSUB_SATURATE_EN defined: when V=1, the stored result is clamped.
//   Clamp is 2^(WIDTH-1)-1 if A_msb==0, else 2^(WIDTH-1) (0x7F/0x80 for WIDTH=8).
//   N and Z are taken from the clamped value. V is still reported as 1.
//  Undefined: the stored result is Sum unmodified (wrap-around).
// STRUCTURE
//  Package addsub_pkg: WIDTH default, flag bit indices (FLG_CB=0, FLG_V=1, FLG_Z=2, FLG_N=3),
//   the flags struct/typedef, and the saturation constants.
//  Sub-module addsub_flag_calc: combinational flag derivation plus the optional clamp.
//   It is instantiated once ahead of the FIFO write port.
// TESTING
//  1. Add 100+27 (Sum=0x7F, Cout=0) -> out_result=0x7F, flags N=0 Z=0 V=0 CB=0, one cycle after push.
//  2. Add 100+28 (Sum=0x80) -> V=1, N=1, ovf_count 0->1.
//     With ADDSUB_SATURATE_EN: result=0x7F, N=0.
//  3. Sub 5-7 (Sum=0xFE, Cout=0) -> CB(borrow)=1, N=1.
//     Sub 5-5 (Sum=0x00, Cout=1) -> Z=1, CB=0.
//  4. Hold out_ready=0 and push 3 -> in_ready low after the 2nd push; the 3rd is held.
//     Release out_ready -> order is 1,2,3; in_ready rises the cycle after the first pop.
//  5. At count=1, push and pop in the same cycle for 10 cycles -> count stays 1.
//     No loss or duplication; pointers wrap correctly.
//  6. Assert rst with 2 entries queued -> next cycle out_valid=0, ovf_count=0, in_ready=0 while rst is high.
//     After rst deasserts, in_ready=1 and the first new push is the head.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the adder/subtractor result stage.
package addsub_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned FLAGS_W    = 4;

    localparam int unsigned FLG_CB = 0;
    localparam int unsigned FLG_V  = 1;
    localparam int unsigned FLG_Z  = 2;
    localparam int unsigned FLG_N  = 3;

    // Field order matches the FLG_* bit indices: {N,Z,V,CB}
    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic cb;
    } flags_t;

    localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/addsub_flag_calc.sv
// Combinational status-flag derivation for one adder/subtractor result.
// ADDSUB_SATURATE_EN: clamp the result on signed overflow instead of wrapping.
module addsub_flag_calc
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             sub,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    logic v;

    always_comb begin
        v      = (a_msb == (b_msb ^ sub)) && (sum[WIDTH-1] != a_msb);
        result = sum;
`ifdef ADDSUB_SATURATE_EN
        // Overflow always has the sign of A, so A_msb picks the clamp rail
        if (v) begin
            result = {a_msb, {(WIDTH-1){~a_msb}}};
        end
`endif
        flags    = '0;
        flags.cb = sub ? ~cout : cout;
        flags.v  = v;
        flags.n  = result[WIDTH-1];
        flags.z  = (result == '0);
    end

endmodule

// File: rtl/addsub_result_stage.sv
// Result stage: captures adder output with flags into a small FIFO behind a valid/ready port.
// ADDSUB_SATURATE_EN selects clamped results on overflow (see addsub_flag_calc).
module addsub_result_stage
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH,
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   Sum,
    input  logic               Cout,
    input  logic               Sub,
    input  logic               A_msb,
    input  logic               B_msb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [FLAGS_W-1:0] out_flags,
    output logic [7:0]         ovf_count,
    input  logic               ovf_clr
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam logic [7:0]  OVF_MAX = 8'hFF;

    logic [WIDTH-1:0] mem_result [DEPTH];
    flags_t           mem_flags  [DEPTH];

    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [7:0]       ovf_nxt;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] calc_result;
    flags_t           calc_flags;

    addsub_flag_calc #(
        .WIDTH (WIDTH)
    ) u_flag_calc (
        .sum    (Sum),
        .cout   (Cout),
        .sub    (Sub),
        .a_msb  (A_msb),
        .b_msb  (B_msb),
        .result (calc_result),
        .flags  (calc_flags)
    );

    // Ready depends on occupancy only, so a pop never frees a slot in the same cycle
    assign in_ready   = (count != CNT_W'(DEPTH)) & ~rst;
    assign out_valid  = (count != '0);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign out_result = mem_result[rd_ptr];
    assign out_flags  = mem_flags[rd_ptr];

    // Next-state for pointers, occupancy and overflow counter
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        ovf_nxt    = ovf_count;

        if (push) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase

        if (ovf_clr) begin
            ovf_nxt = '0;
        end else if (push && calc_flags.v && (ovf_count != OVF_MAX)) begin
            ovf_nxt = ovf_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_result[i] <= '0;
                mem_flags[i]  <= '0;
            end
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            ovf_count <= ovf_nxt;
            if (push) begin
                mem_result[wr_ptr] <= calc_result;
                mem_flags[wr_ptr]  <= calc_flags;
            end
        end
    end

endmodule

// File: tb/tb_addsub_result_stage.sv
// Scoreboard bench for addsub_result_stage; honours ADDSUB_SATURATE_EN like the RTL.
module tb_addsub_result_stage;

    localparam int unsigned DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sum;
    logic       cout;
    logic       sub;
    logic       a_msb;
    logic       b_msb;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [3:0] out_flags;
    logic [7:0] ovf_count;
    logic       ovf_clr;

    int tests  = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    logic [11:0] cur_exp;
    int          ovf_model = 0;
    bit          accepted;

    always #5 clk = ~clk;

    addsub_result_stage #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Sum        (sum),
        .Cout       (cout),
        .Sub        (sub),
        .A_msb      (a_msb),
        .B_msb      (b_msb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .ovf_count  (ovf_count),
        .ovf_clr    (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference from signed/unsigned arithmetic on the original operands: {result, N,Z,V,CB}
    function automatic logic [11:0] model(input int a, input int b, input bit s);
        int         sa;
        int         sb;
        int         t;
        bit         v;
        bit         cb;
        logic [7:0] r;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        t  = s ? sa - sb : sa + sb;
        v  = (t > 127) || (t < -128);
        cb = s ? (a < b) : ((a + b) > 255);
        r  = 8'(t);
`ifdef ADDSUB_SATURATE_EN
        if (v) r = (t > 127) ? 8'h7F : 8'h80;
`endif
        return {r, r[7], (r == 8'h00), v, cb};
    endfunction

    task automatic set_in(input int a, input int b, input bit s);
        logic [7:0] a8;
        logic [7:0] b8;
        logic [8:0] full;
        a8       = 8'(a);
        b8       = 8'(b);
        full     = {1'b0, a8} + {1'b0, (s ? ~b8 : b8)} + 9'(s);
        sum      = full[7:0];
        cout     = full[8];
        sub      = s;
        a_msb    = a8[7];
        b_msb    = b8[7];
        in_valid = 1'b1;
        cur_exp  = model(a, b, s);
    endtask

    // One cycle: compare outputs against the scoreboard, then advance the model at the edge
    task automatic tick();
        bit push_m;
        bit pop_m;
        #1;
        push_m = in_valid && !rst && (exp_q.size() < DEPTH);
        pop_m  = out_ready && (exp_q.size() != 0);
        check("in_ready", 32'(in_ready), 32'(push_m || (!rst && exp_q.size() < DEPTH)));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("ovf_count", 32'(ovf_count), 32'(ovf_model));
        if (exp_q.size() != 0) begin
            check("out_result", 32'(out_result), 32'(exp_q[0][11:4]));
            check("out_flags", 32'(out_flags), 32'(exp_q[0][3:0]));
        end
        accepted = push_m;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            ovf_model = 0;
        end else begin
            if (pop_m) void'(exp_q.pop_front());
            if (push_m) exp_q.push_back(cur_exp);
            if (ovf_clr) ovf_model = 0;
            else if (push_m && cur_exp[1] && ovf_model < 255) ovf_model++;
        end
        @(negedge clk);
    endtask

    task automatic send(input int a, input int b, input bit s);
        set_in(a, b, s);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (accepted) break;
        end
        if (!accepted) check("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        sum       = '0;
        cout      = 1'b0;
        sub       = 1'b0;
        a_msb     = 1'b0;
        b_msb     = 1'b0;
        cur_exp   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        check("rst_result", 32'(out_result), 32'(0));
        check("rst_flags", 32'(out_flags), 32'(0));
        rst = 1'b0;
        tick();

        // Basic add/sub flag cases
        send(100, 27, 1'b0);
        tick();
        send(100, 28, 1'b0);
        tick();
        check("ovf_after_v", 32'(ovf_count), 32'(1));
        send(5, 7, 1'b1);
        tick();
        send(5, 5, 1'b1);
        tick();
        send(200, 100, 1'b0);
        send(128, 1, 1'b1);
        tick();
        tick();

        // Stall: two fill the FIFO, third waits for space
        out_ready = 1'b0;
        send(1, 0, 1'b0);
        send(2, 0, 1'b0);
        set_in(3, 0, 1'b0);
        tick();
        check("full_held", 32'(accepted), 32'(0));
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (accepted) break;
        end
        check("third_accepted", 32'(accepted), 32'(1));
        in_valid = 1'b0;
        repeat (3) tick();

        // Steady push+pop at count=1 across pointer wrap
        send(10, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            set_in(11 + i, 3, i[0]);
            tick();
            check("stream_accept", 32'(accepted), 32'(1));
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // Clear concurrent with an overflowing push yields zero
        set_in(127, 1, 1'b0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr  = 1'b0;
        in_valid = 1'b0;
        tick();
        check("clr_priority", 32'(ovf_count), 32'(0));
        tick();

        // Saturation of the overflow counter
        for (int i = 0; i < 260; i++) begin
            set_in(100, 28, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("ovf_saturated", 32'(ovf_count), 32'(255));

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) set_in(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            else in_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            ovf_clr   = ($urandom_range(0, 15) == 0);
            tick();
        end
        in_valid  = 1'b0;
        ovf_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Reset with two entries queued
        out_ready = 1'b0;
        send(100, 28, 1'b0);
        send(50, 60, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_ovf", 32'(ovf_count), 32'(0));
        check("rst_clear_res", 32'(out_result), 32'(0));
        rst       = 1'b0;
        out_ready = 1'b1;
        send(9, 4, 1'b1);
        tick();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
